// File: rtl/fetch_pipe_ctrl.sv
// rtl/fetch_pipe_ctrl.sv - PC, IF/ID register and ID/EX control register with stall/redirect handling
module fetch_pipe_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CTRL_W   = 12,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              idflush,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic              jump,
   input  logic [31:0]       jump_target,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic [CTRL_W-1:0] idex_ctrl_in,
   output logic [31:0]       imem_addr,
   output logic [31:0]       pc,
   output logic [31:0]       ifid_instr,
   output logic [31:0]       ifid_pc4,
   output logic              ifid_valid,
   output logic [CTRL_W-1:0] idex_ctrl,
   output logic              idex_valid,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [31:0]       pc_plus4;
   logic [31:0]       redirect_target;
   logic              redirect;
   logic [31:0]       pc_d;
   logic [31:0]       ifid_instr_d;
   logic [31:0]       ifid_pc4_d;
   logic              ifid_valid_d;
   logic [CTRL_W-1:0] idex_ctrl_d;
   logic              idex_valid_d;

   assign imem_addr       = pc;
   assign pc_plus4        = pc + 32'd4;
   assign redirect        = branch_taken | jump;
   // Branch wins over jump; targets are forced word aligned.
   assign redirect_target = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

   always_comb begin
      pc_d         = pc;
      ifid_instr_d = ifid_instr;
      ifid_pc4_d   = ifid_pc4;
      ifid_valid_d = ifid_valid;
      idex_ctrl_d  = '0;
      idex_valid_d = 1'b0;
      if (!stall) begin
         if (!idflush && ifid_valid) begin
            idex_ctrl_d  = idex_ctrl_in;
            idex_valid_d = 1'b1;
         end
         if (redirect || !imem_ready) begin
            ifid_instr_d = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
            if (redirect) pc_d = redirect_target;
         end else begin
            pc_d         = pc_plus4;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_PC;
         ifid_instr <= 32'h0;
         ifid_pc4   <= 32'h0;
         ifid_valid <= 1'b0;
         idex_ctrl  <= '0;
         idex_valid <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         pc         <= pc_d;
         ifid_instr <= ifid_instr_d;
         ifid_pc4   <= ifid_pc4_d;
         ifid_valid <= ifid_valid_d;
         idex_ctrl  <= idex_ctrl_d;
         idex_valid <= idex_valid_d;
         // Counters stick at all-ones rather than wrapping.
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_ONE;
         if (!stall && redirect && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: doc/fetch_pipe_ctrl.md
# fetch_pipe_ctrl

Owns the program counter, the IF/ID pipeline register and the control half of the ID/EX register. Executes the stall, bubble and redirect decisions that the hazard-detection unit and the ID-stage branch comparator produce. Sits between instruction memory, the decoder and the execute stage of the 5-stage MIPS pipeline. It also keeps saturating stall-cycle and flush counters for performance debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CTRL_W, 12, width of the decoded control bundle passed ID→EX
- CNT_W, 16, width of each performance counter

- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; affects all state
- stall  in  1  from hazard unit: freeze PC and IF/ID
- idflush  in  1  from hazard unit: load zeros into ID/EX control
- branch_taken  in  1  ID-stage beq/bne resolved taken
- branch_target  in  32  ID-stage computed target
- jump  in  1  ID-stage j/jal decoded
- jump_target  in  32  ID-stage jump address
- imem_ready  in  1  instruction memory data valid this cycle
- imem_rdata  in  32  instruction at imem_addr, combinational
- idex_ctrl_in  in  CTRL_W  decoder output for the instruction in ID
- imem_addr  out  32  equals pc
- pc  out  32  current fetch PC
- ifid_instr  out  32  IF/ID instruction (0 = nop)
- ifid_pc4  out  32  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction
- idex_ctrl  out  CTRL_W  ID/EX control bundle
- idex_valid  out  1  ID/EX holds a real instruction
- stall_cnt  out  CNT_W  cycles with stall=1
- flush_cnt  out  CNT_W  redirects (branch taken or jump)

## Operation
- Per-cycle priority: reset > stall > branch_taken > jump > !imem_ready > normal fetch.
- reset: pc=RESET_PC; ifid_instr=0, ifid_pc4=0, ifid_valid=0; idex_ctrl=0, idex_valid=0; both counters 0.
- stall=1: pc and IF/ID hold. idex_ctrl←0 and idex_valid←0 regardless of idflush. branch_taken/jump are ignored, because compare operands are not valid under stall. stall_cnt+1.
- branch_taken=1 (no stall): pc←{branch_target[31:2],2'b00}. IF/ID←bubble (instr 0, pc4 0, valid 0). ID/EX takes the branch itself (see ID/EX rule). flush_cnt+1.
- jump=1 (no stall, no branch_taken): same as branch with jump_target.
- imem_ready=0 (no stall/redirect): pc holds. IF/ID←bubble. ID/EX advances per ID/EX rule.
- normal: pc←pc+4. ifid_instr←imem_rdata, ifid_pc4←pc+4, ifid_valid←1.
- ID/EX rule when stall=0: if idflush=1 or ifid_valid=0, idex_ctrl←0 and idex_valid←0. Otherwise idex_ctrl←idex_ctrl_in and idex_valid←1.
- idflush=1 with stall=0 zeroes ID/EX only; PC and IF/ID follow the remaining priority.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Counters saturate at all-ones and never wrap.

## Timing
- All outputs are registered except imem_addr, which is a wire of pc.
- Fetch latency: instruction at pc appears on ifid_instr one cycle after the edge that samples it.
- Redirect penalty: exactly one bubble in IF/ID. The target instruction appears on ifid_instr two edges after branch_taken is sampled.
- Load-use stall: one cycle of stall produces one ID/EX bubble. The stalled instruction re-enters ID/EX on the next non-stall edge.
- stall held N cycles: pc/IF/ID frozen N edges, N bubbles into ID/EX, stall_cnt+N (saturating).
- Reset asserted mid-stall or mid-redirect: the next edge applies reset values only, and pending redirects are discarded. The first fetch after reset release is at RESET_PC.

## Test plan
- Reset then 4 normal cycles with imem_rdata=0x20080001..04: pc reaches 0x10. ifid_instr=0x20080004, ifid_pc4=0x10, idex_valid=1 from cycle 2.
- One-cycle stall+idflush at pc=0x8: pc stays 0x8 and IF/ID stays unchanged for that edge. idex_ctrl=0, idex_valid=0. stall_cnt=1, then pc→0xC.
- branch_taken with target 0x40 at pc=0x14: pc=0x40, ifid_valid=0, idex_ctrl=branch ctrl. Next edge: ifid_pc4=0x44. flush_cnt=1.
- branch_taken and stall together: branch ignored, pc held, flush_cnt unchanged. On the following edge, branch_taken with stall=0 redirects.
- branch_target=0x43 → pc=0x40. pc=0xFFFF_FFFC normal fetch → pc=0x0.
- imem_ready=0 for 3 cycles: pc held, 3 IF/ID bubbles. Then a 0x12 reset mid-sequence returns all outputs to reset values on the next edge.
